// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   loaderState_t  - loader FSM state encoding
//   HDR_BYTES      - bytes in the big-endian word-count header
//   BYTES_PER_WORD - bytes per instruction word (big-endian)
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } loaderState_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// loader_word_packer: big-endian byte-to-word shift register.
//   clk       - system clock
//   rst       - synchronous active-high reset
//   clear     - restart assembly at byte 0 (start of the data phase)
//   shiftEn   - a byte is being accepted this cycle
//   byteIn    - incoming byte
//   wordNext  - word formed by the bytes held so far plus byteIn
//   wordDone  - byteIn is the last byte of a word (valid with shiftEn)
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        shiftEn,
  input  logic [7:0]                  byteIn,
  output logic [8*BYTES_PER_WORD-1:0] wordNext,
  output logic                        wordDone
);

  localparam int IDXW = $clog2(BYTES_PER_WORD);

  // Only the leading bytes need storage; the final byte is taken straight
  // from byteIn so the full word is available on the completing handshake.
  logic [8*(BYTES_PER_WORD-1)-1:0] shiftReg;
  logic [IDXW-1:0]                 byteIdx;

  assign wordNext = {shiftReg, byteIn};
  assign wordDone = shiftEn && (byteIdx == IDXW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shiftReg <= '0;
      byteIdx  <= '0;
    end else if (shiftEn) begin
      shiftReg <= wordNext[8*(BYTES_PER_WORD-1)-1:0];
      byteIdx  <= byteIdx + 1'b1;  // wraps naturally at a word boundary
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a host byte stream into instruction memory and holds
// the core in reset until the whole image is written.
// Stream: 16-bit word count N (high byte first), then N big-endian words.
//   CLK, Reset         - clock, synchronous active-high reset
//   start              - begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid/ready   - host byte handshake, byte_data carries the byte
//   imem_we/addr/wdata - registered instruction-memory write port
//   core_reset         - hold core in reset (low only in DONE)
//   done, error        - image loaded / header rejected
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  loaderState_t              state;
  logic [8*HDR_BYTES-1:0]    wordCnt;
  logic [ADDR_WIDTH-1:0]     wordAddr;
  logic [ADDR_WIDTH-1:0]     lastAddr;
  logic [8*HDR_BYTES-1:0]    hdrCnt;
  logic                      xfer;
  logic                      packClear;
  logic                      packShift;
  logic [31:0]               wordNext;
  logic                      wordDone;

  assign byte_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
  assign xfer       = byte_valid && byte_ready;
  assign hdrCnt     = {wordCnt[15:8], byte_data};
  // N is range-checked against DEPTH, so truncation to the address width is safe.
  assign lastAddr   = ADDR_WIDTH'(wordCnt - 16'd1);
  assign packClear  = (state == HDR_LO) && xfer;
  assign packShift  = (state == DATA) && xfer;

  loader_word_packer uPacker (
    .clk      (CLK),
    .rst      (Reset),
    .clear    (packClear),
    .shiftEn  (packShift),
    .byteIn   (byte_data),
    .wordNext (wordNext),
    .wordDone (wordDone)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      wordCnt    <= '0;
      wordAddr   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE:
          if (start) state <= HDR_HI;
        HDR_HI:
          if (xfer) begin
            wordCnt[15:8] <= byte_data;
            state         <= HDR_LO;
          end
        HDR_LO:
          if (xfer) begin
            wordCnt[7:0] <= byte_data;
            if (hdrCnt == 16'd0 || 32'(hdrCnt) > DEPTH) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state    <= DATA;
              wordAddr <= '0;
            end
          end
        DATA:
          // Write strobe is registered here so it rises one cycle after the
          // handshake of the word's final byte.
          if (wordDone) begin
            state      <= WRITE;
            imem_we    <= 1'b1;
            imem_addr  <= wordAddr;
            imem_wdata <= wordNext;
          end
        WRITE:
          if (wordAddr == lastAddr) begin
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
          end else begin
            wordAddr <= wordAddr + 1'b1;
            state    <= DATA;
          end
        DONE:
          if (start) begin
            state      <= HDR_HI;
            done       <= 1'b0;
            core_reset <= 1'b1;
          end
        ERR:
          if (start) begin
            state <= HDR_HI;
            error <= 1'b0;
          end
        default:
          state <= IDLE;
      endcase
    end
  end

endmodule
